i2s_master: RTL and testbench

- I2S receive master for a digital MEMS microphone.
- From the single system clock it generates the bit clock (i2s_bclk) and the word-select / left-right clock (i2s_lrcl).
- It shifts in serial PCM data from the microphone (i2s_dout) and pushes each captured, sign-extended sample into a downstream FIFO through a write strobe.
- It sits between the microphone pins and the audio-sample FIFO of the capture pipeline.

---
 rtl/i2s_master_if.sv | 21 ++
 rtl/i2s_master.sv | 98 +++++++++
 tb/tb_i2s_master.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/i2s_master_if.sv
// I2S microphone pins plus the audio-sample FIFO write port of the capture master.
interface i2s_master_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  i2s_bclk;
  logic                  i2s_lrcl;
  logic                  i2s_dout;
  logic [DATA_WIDTH-1:0] fifo_din;
  logic                  fifo_w_stb;
  logic                  fifo_full;

  modport master (
    output i2s_bclk, i2s_lrcl, fifo_din, fifo_w_stb,
    input  i2s_dout, fifo_full
  );

  modport slave (
    input  i2s_bclk, i2s_lrcl, fifo_din, fifo_w_stb,
    output i2s_dout, fifo_full
  );
endinterface

// File: rtl/i2s_master.sv
// I2S receive master: generates bclk/lrcl, captures MSB-first PCM, writes sign-extended samples 1 clk after the last bit.
// No backpressure: a write meeting fifo_full is dropped. Define I2S_STEREO_EN to also capture the right slot.
module i2s_master #(
  parameter int DATA_WIDTH    = 32,
  parameter int PCM_PRECISION = 18,
  parameter int BCLK_DIV      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  i2s_master_if.master  bus
);
  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * DATA_WIDTH);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(2 * DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] SLOT_LEN  = BIT_W'(DATA_WIDTH);
  localparam logic [BIT_W-1:0] PCM_LAST  = BIT_W'(PCM_PRECISION);

  logic [DIV_W-1:0]         div_cnt;
  logic [BIT_W-1:0]         bit_cnt;
  logic [PCM_PRECISION-1:0] shreg;
  logic                     bclk;
  logic                     lrcl;
  logic                     pend;
  logic [DATA_WIDTH-1:0]    din;
  logic                     w_stb;

  logic                     tick;
  logic                     rise;
  logic                     fall;
  logic                     in_right;
  logic                     slot_en;
  logic                     cap_en;
  logic [BIT_W-1:0]         slot_bit;
  logic [BIT_W-1:0]         bit_nxt;
  logic [PCM_PRECISION:0]   shift_nxt;

  assign tick      = (div_cnt == DIV_LAST);
  assign rise      = tick & ~bclk;
  assign fall      = tick &  bclk;
  assign in_right  = (bit_cnt >= SLOT_LEN);
  assign slot_bit  = in_right ? (bit_cnt - SLOT_LEN) : bit_cnt;
  assign bit_nxt   = (bit_cnt == BIT_LAST) ? '0 : (bit_cnt + BIT_W'(1));
  assign cap_en    = (slot_bit >= BIT_W'(1)) && (slot_bit <= PCM_LAST);
  // Concatenate then truncate so the shift also works for a 1-bit sample.
  assign shift_nxt = {shreg, bus.i2s_dout};

`ifdef I2S_STEREO_EN
  assign slot_en = 1'b1;
`else
  assign slot_en = ~in_right;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      bclk    <= 1'b0;
      lrcl    <= 1'b0;
      pend    <= 1'b0;
      din     <= '0;
      w_stb   <= 1'b0;
    end else begin
      w_stb <= 1'b0;

      if (tick) begin
        div_cnt <= '0;
        bclk    <= ~bclk;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end

      if (fall) begin
        bit_cnt <= bit_nxt;
        lrcl    <= (bit_nxt >= SLOT_LEN);
      end

      if (rise && cap_en) begin
        shreg <= shift_nxt[PCM_PRECISION-1:0];
      end

      pend <= rise && (slot_bit == PCM_LAST) && slot_en;

      // din tracks every completed sample; only the strobe honours fifo_full.
      if (pend) begin
        din   <= {{(DATA_WIDTH-PCM_PRECISION){shreg[PCM_PRECISION-1]}}, shreg};
        w_stb <= ~bus.fifo_full;
      end
    end
  end

  assign bus.i2s_bclk   = bclk;
  assign bus.i2s_lrcl   = lrcl;
  assign bus.fifo_din   = din;
  assign bus.fifo_w_stb = w_stb;
endmodule

// File: tb/tb_i2s_master.sv
// Directed bench for i2s_master: microphone model on bclk falls, strobe log checked against hand-computed cycles/values.
module tb_i2s_master;
  localparam int PCM = 18;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_tests;
  int   n_fail;
  int   fcnt;
  logic [PCM-1:0] left_word;
  logic [PCM-1:0] right_word;
  int   stb_t[$];
  logic [31:0] stb_v[$];
  int   exp_t[$];
  logic [31:0] exp_v[$];

  i2s_master_if #(.DATA_WIDTH(32)) bus ();

  i2s_master #(
    .DATA_WIDTH(32),
    .PCM_PRECISION(PCM),
    .BCLK_DIV(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Microphone: drives the bit for the new bit position right after each bclk fall.
  always @(negedge bus.i2s_bclk or negedge rst_n) begin
    int s;
    logic [PCM-1:0] w;
    if (!rst_n) begin
      fcnt = 0;
      bus.i2s_dout = 1'b0;
    end else begin
      fcnt = (fcnt + 1) % 64;
      s = fcnt % 32;
      w = (fcnt < 32) ? left_word : right_word;
      if (s >= 1 && s <= PCM) bus.i2s_dout = w[PCM - s];
      else                    bus.i2s_dout = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.fifo_w_stb === 1'b1) begin
      stb_t.push_back(cyc);
      stb_v.push_back(bus.fifo_din);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_for(input bit use_lrcl, input logic val, input int max);
    for (int i = 0; i < max; i++) begin
      @(posedge clk);
      #1;
      if ((use_lrcl ? bus.i2s_lrcl : bus.i2s_bclk) === val) return;
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b1;
    bus.fifo_full = 1'b0;
    left_word  = 18'h2A5A5;
    right_word = 18'h3FFFF;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_bclk", bus.i2s_bclk, 0);
    check("rst_lrcl", bus.i2s_lrcl, 0);
    check("rst_din",  bus.fifo_din, 0);
    check("rst_stb",  bus.fifo_w_stb, 0);
    rst_n = 1'b1;

    wait_for(0, 1'b1, 100);   check("bclk_first_rise", cyc, 16);
    wait_for(0, 1'b0, 100);   check("bclk_first_fall", cyc, 32);
    wait_for(0, 1'b1, 100);   check("bclk_second_rise", cyc, 48);
    wait_for(1, 1'b1, 3000);  check("lrcl_rise", cyc, 1024);
    wait_for(1, 1'b0, 3000);  check("lrcl_fall", cyc, 2048);
    wait_for(1, 1'b1, 3000);  check("lrcl_rise2", cyc, 3072);

    left_word = 18'h01234;
    wait_cyc(5000);
    left_word = 18'h00001;
    wait_cyc(6400);
    bus.fifo_full = 1'b1;
    wait_cyc(6800);
    check("din_on_overflow", bus.fifo_din, 32'h0000_0001);
    wait_cyc(6900);
    bus.fifo_full = 1'b0;
    wait_cyc(9900);
    left_word = 18'h2A5A5;
    wait_cyc(10300);

`ifdef I2S_STEREO_EN
    exp_t = {593, 1617, 2641, 3665, 4689, 5713, 7761, 8785, 9809};
    exp_v = {32'hFFFE_A5A5, 32'hFFFF_FFFF, 32'hFFFE_A5A5, 32'hFFFF_FFFF, 32'h0000_1234,
             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF};
`else
    exp_t = {593, 2641, 4689, 8785};
    exp_v = {32'hFFFE_A5A5, 32'hFFFE_A5A5, 32'h0000_1234, 32'h0000_0001};
`endif
    check("stb_count", stb_t.size(), exp_t.size());
    for (int i = 0; i < exp_t.size(); i++) begin
      if (i < stb_t.size()) begin
        check($sformatf("stb%0d_cyc", i), stb_t[i], exp_t[i]);
        check($sformatf("stb%0d_din", i), stb_v[i], exp_v[i]);
      end
    end

    // Mid-left-slot reset: bclk is high here and fifo_din is nonzero.
    rst_n = 1'b0;
    #1;
    check("midrst_bclk", bus.i2s_bclk, 0);
    check("midrst_lrcl", bus.i2s_lrcl, 0);
    check("midrst_din",  bus.fifo_din, 0);
    check("midrst_stb",  bus.fifo_w_stb, 0);
    stb_t.delete();
    stb_v.delete();
    repeat (5) @(negedge clk);
    left_word = 18'h01234;
    rst_n = 1'b1;
    wait_cyc(700);
    check("post_rst_count", stb_t.size(), 1);
    if (stb_t.size() > 0) begin
      check("post_rst_cyc", stb_t[0], 593);
      check("post_rst_din", stb_v[0], 32'h0000_1234);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
